id_imm_extend: RTL and testbench
================================

// Module: id_imm_extend
// PURPOSE
//  Parametrised immediate-generation stage for the ID pipeline. Successor to the fixed 8->16 sign extender.
//  Extends the raw instruction offset field by mode: sign-extend 4/8/12, zero-extend 8, or branch form (sext8 << 1).
//  Holds a prefix register so a PREFIX instruction supplies the upper bits of the next immediate.
//  Registered output with valid/ready handshake toward EX.
// PARAMETERS
//  DATA_W   16  output immediate width; must satisfy DATA_W >= FIELD_W+1
//  FIELD_W  12  raw offset field width; must be >= 8
//  PFX_W    8   prefix register width; PFX_W < DATA_W, low part = DATA_W-PFX_W bits
// PORTS
//  clk        in   1        sole clock, rising edge
//  rst_n      in   1        reset, asynchronous, active-low
//  flush      in   1        pipeline flush from branch resolution
//  in_valid   in   1        decode presents a field
//  in_ready   out  1        stage accepts the field this cycle
//  in_prefix  in   1        this beat is a PREFIX instruction
//  in_mode    in   3        0 SEXT4, 1 SEXT8, 2 SEXT12, 3 ZEXT8, 4 BR_SEXT8_SHL1, 5-7 reserved
//  in_field   in   FIELD_W  raw offset field, LSB-aligned
//  out_valid  out  1        out_imm/out_err valid
//  out_ready  in   1        EX consumes this cycle
//  out_imm    out  DATA_W   extended immediate
//  out_err    out  1        reserved mode was used
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_imm=0, out_err=0, state=IDLE, pfx_reg=0; all take effect immediately.
//  in_ready = !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  Latency: accepted non-prefix beat appears on out_* the next rising edge (1 cycle).
//  Extension: SEXTn replicates field[n-1] into bits DATA_W-1..n; ZEXT8 fills zeros;
//   BR mode = sext8(field[7:0]) << 1, MSB discarded, bit0 = 0. Field bits above n ignored.
//  Reserved mode: out_imm=0, out_err=1, beat still produces output; prefix (if held) is consumed.
//  FSM states: IDLE, PFX_HELD.
//   IDLE --accept && in_prefix--> PFX_HELD (pfx_reg <= in_field[PFX_W-1:0]; no output produced).
//   PFX_HELD --accept && in_prefix--> PFX_HELD (pfx_reg overwritten; last prefix wins).
//   PFX_HELD --accept && !in_prefix--> IDLE; out_imm = {pfx_reg, in_field[DATA_W-PFX_W-1:0]} (mode ignored
//    except reserved, which still gives out_imm=0, out_err=1).
//   Any state --flush--> IDLE, pfx_reg=0.
//  Backpressure: while out_valid && !out_ready, out_imm/out_err held stable, no new accept.
//  Simultaneous out_ready and accept: output register reloads same edge (full throughput, 1/cycle).
//  Flush: out_valid<=0 on the edge, in_ready=0 during the flush cycle, input beat dropped, flush beats accept.
//  Prefix beat with out_valid && !out_ready: not accepted (same in_ready rule for all beats).
//  No combinational path from in_* to out_*; in_ready depends only on flush, out_valid, out_ready.
// STRUCTURE
//  Shared package id_pkg: mode localparams (IMM_SEXT4..IMM_BR8), FSM state typedef/encodings.
//  Sub-module imm_ext_core: purely combinational (mode, field) -> (value, err); parametrised by DATA_W/FIELD_W.
//  Top holds FSM, pfx_reg, output register and handshake logic.
// TESTING (DATA_W=16, FIELD_W=12, PFX_W=8, out_ready=1 unless stated)
//  1 SEXT8 0x0FF -> out_imm 0xFFFF one cycle later; SEXT8 0x032 -> 0x0032; back-to-back, one result per cycle.
//  2 SEXT4 0x008 -> 0xFFF8; SEXT12 0x800 -> 0xF800; ZEXT8 0x0FF -> 0x00FF; BR 0x080 -> 0xFF00; mode 6 -> 0x0000, out_err=1.
//  3 PREFIX 0x012 then SEXT8 0x034 -> no output on prefix beat, then out_imm 0x1234; next SEXT8 0x034 -> 0x0034.
//  4 out_ready=0 for 3 cycles with SEXT8 0x0F0 held: out_imm stays 0xFFF0, in_ready=0; release -> drains, next beat accepted same edge.
//  5 PREFIX 0x0AB, flush with in_valid=1, then SEXT8 0x080 -> flush beat dropped, out_valid=0, result 0xFF80 (prefix cleared).
//  6 rst_n low mid-cycle with out_valid=1 and PFX_HELD -> out_valid=0, out_imm=0 before next edge; after release SEXT8 0x001 -> 0x0001.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the ID immediate stage: extension mode codes and prefix FSM states.
package id_pkg;

  localparam logic [2:0] IMM_SEXT4  = 3'd0;
  localparam logic [2:0] IMM_SEXT8  = 3'd1;
  localparam logic [2:0] IMM_SEXT12 = 3'd2;
  localparam logic [2:0] IMM_ZEXT8  = 3'd3;
  localparam logic [2:0] IMM_BR8    = 3'd4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_PFX_HELD = 1'b1
  } pfx_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (mode, field) -> (value, err); no state, no latency.
// Reserved modes return zero with err set; field bits above the selected width are ignored.
module imm_ext_core
  import id_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FIELD_W = 12
) (
  input  logic [2:0]         mode,
  input  logic [FIELD_W-1:0] field,
  output logic [DATA_W-1:0]  value,
  output logic               err
);

  // Working width wide enough for both the output and a 12-bit source field.
  localparam int FW = (DATA_W > 12) ? DATA_W : 12;

  logic [FW-1:0] fx;

  function automatic logic [DATA_W-1:0] sext(input logic [FW-1:0] f, input int n);
    logic [FW-1:0] low_mask;
    logic [FW-1:0] r;
    logic          sign;
    low_mask = (FW'(1) << n) - FW'(1);
    sign     = |(f & (FW'(1) << (n - 1)));
    r        = sign ? (f | ~low_mask) : (f & low_mask);
    return r[DATA_W-1:0];
  endfunction

  always_comb begin
    fx = '0;
    fx[FIELD_W-1:0] = field;
  end

  always_comb begin
    value = '0;
    err   = 1'b0;
    case (mode)
      IMM_SEXT4:  value = sext(fx, 4);
      IMM_SEXT8:  value = sext(fx, 8);
      IMM_SEXT12: value = sext(fx, 12);
      IMM_ZEXT8:  value = DATA_W'(fx[7:0]);
      IMM_BR8:    value = sext(fx, 8) << 1;
      default:    err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_imm_extend.sv
// ID immediate stage: extends the offset field by mode, with a PREFIX register for upper bits; 1-cycle registered output.
// Stalls input while the output is held (out_valid && !out_ready); flush drops the input beat and clears the prefix.
module id_imm_extend
  import id_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FIELD_W = 12,
  parameter int PFX_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_prefix,
  input  logic [2:0]         in_mode,
  input  logic [FIELD_W-1:0] in_field,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_err
);

  localparam int LOW_W = DATA_W - PFX_W;
  localparam int CP_W  = (LOW_W < FIELD_W) ? LOW_W : FIELD_W;
  localparam int PL_W  = (PFX_W < FIELD_W) ? PFX_W : FIELD_W;

  pfx_state_t        state;
  logic [PFX_W-1:0]  pfx_reg;
  logic [PFX_W-1:0]  pfx_next;
  logic [DATA_W-1:0] ext_value;
  logic              ext_err;
  logic [DATA_W-1:0] pfx_imm;
  logic              accept;

  imm_ext_core #(
    .DATA_W  (DATA_W),
    .FIELD_W (FIELD_W)
  ) u_core (
    .mode  (in_mode),
    .field (in_field),
    .value (ext_value),
    .err   (ext_err)
  );

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Prefixed immediate: held prefix on top, raw field bits below (mode does not apply).
  always_comb begin
    pfx_imm = '0;
    pfx_imm[DATA_W-1 -: PFX_W] = pfx_reg;
    pfx_imm[CP_W-1:0] = in_field[CP_W-1:0];
  end

  always_comb begin
    pfx_next = '0;
    pfx_next[PL_W-1:0] = in_field[PL_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pfx_reg   <= '0;
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      pfx_reg   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_prefix) begin
          state   <= ST_PFX_HELD;
          pfx_reg <= pfx_next;
        end else begin
          state     <= ST_IDLE;
          pfx_reg   <= '0;
          out_valid <= 1'b1;
          out_err   <= ext_err;
          if (ext_err) begin
            out_imm <= '0;
          end else if (state == ST_PFX_HELD) begin
            out_imm <= pfx_imm;
          end else begin
            out_imm <= ext_value;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_id_imm_extend.sv
// Self-checking bench for id_imm_extend: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_id_imm_extend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_prefix;
  logic [2:0]  in_mode;
  logic [11:0] in_field;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  // Reference model state: what the output register and prefix should hold.
  logic        m_ov, m_err, m_held;
  logic [15:0] m_imm;
  logic [7:0]  m_pfx;

  typedef struct {
    logic [2:0]  m;
    logic [11:0] f;
    logic [15:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs[10] = '{
    '{3'd1, 12'h0FF, 16'hFFFF, 1'b0},
    '{3'd1, 12'h032, 16'h0032, 1'b0},
    '{3'd0, 12'h008, 16'hFFF8, 1'b0},
    '{3'd2, 12'h800, 16'hF800, 1'b0},
    '{3'd3, 12'h0FF, 16'h00FF, 1'b0},
    '{3'd4, 12'h080, 16'hFF00, 1'b0},
    '{3'd6, 12'h123, 16'h0000, 1'b1},
    '{3'd0, 12'hF07, 16'h0007, 1'b0},
    '{3'd4, 12'h07F, 16'h00FE, 1'b0},
    '{3'd5, 12'hFFF, 16'h0000, 1'b1}
  };

  id_imm_extend dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prefix (in_prefix),
    .in_mode   (in_mode),
    .in_field  (in_field),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_ext(input int mode, input int f);
    int v;
    case (mode)
      0: begin v = f % 16;   if (v >= 8)    v -= 16;   end
      1: begin v = f % 256;  if (v >= 128)  v -= 256;  end
      2: begin v = f % 4096; if (v >= 2048) v -= 4096; end
      3: v = f % 256;
      4: begin v = f % 256;  if (v >= 128)  v -= 256; v = v * 2; end
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_err = 1'b0; m_held = 1'b0; m_imm = 16'h0; m_pfx = 8'h0;
  endtask

  task automatic set_in(input logic v, input logic p, input logic [2:0] m,
                        input logic [11:0] f, input logic ordy, input logic fl);
    in_valid = v; in_prefix = p; in_mode = m; in_field = f; out_ready = ordy; flush = fl;
  endtask

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic tick();
    logic rdy;
    rdy = !flush && (!m_ov || out_ready);
    if (flush) begin
      m_ov = 1'b0; m_held = 1'b0; m_pfx = 8'h0;
    end else begin
      if (m_ov && out_ready) m_ov = 1'b0;
      if (in_valid && rdy) begin
        if (in_prefix) begin
          m_held = 1'b1; m_pfx = in_field[7:0];
        end else begin
          m_ov  = 1'b1;
          m_err = (in_mode > 3'd4);
          if (m_err)       m_imm = 16'h0;
          else if (m_held) m_imm = {m_pfx, in_field[7:0]};
          else             m_imm = ref_ext(int'(in_mode), int'(in_field));
          m_held = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 3'd0, 12'h0, 1, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_imm !== 16'h0) begin bad++; $display("FAIL reset_imm: got %h want 0000", out_imm); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", out_err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_modes();
    foreach (vecs[i]) begin
      set_in(1, 0, vecs[i].m, vecs[i].f, 1, 0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL modes_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL modes_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if (out_imm !== vecs[i].imm) begin bad++; $display("FAIL modes_imm[%0d]: got %h want %h", i, out_imm, vecs[i].imm); end
      total++; if (out_err !== vecs[i].err) begin bad++; $display("FAIL modes_err[%0d]: got %b want %b", i, out_err, vecs[i].err); end
    end
  endtask

  task automatic test_prefix();
    set_in(1, 1, 3'd1, 12'h012, 1, 0);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prefix_no_output: got %b want 0", out_valid); end
    set_in(1, 0, 3'd1, 12'h034, 1, 0);
    tick();
    total++; if (out_valid !== 1'b1 || out_imm !== 16'h1234) begin bad++; $display("FAIL prefix_join: got v=%b %h want v=1 1234", out_valid, out_imm); end
    set_in(1, 0, 3'd1, 12'h034, 1, 0);
    tick();
    total++; if (out_imm !== 16'h0034) begin bad++; $display("FAIL prefix_consumed: got %h want 0034", out_imm); end
  endtask

  task automatic test_backpressure();
    set_in(1, 0, 3'd1, 12'h0F0, 1, 0);
    tick();
    total++; if (out_imm !== 16'hFFF0) begin bad++; $display("FAIL bp_load: got %h want fff0", out_imm); end
    for (int c = 0; c < 3; c++) begin
      set_in(1, 0, 3'd1, 12'h001, 0, 0);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_imm !== 16'hFFF0) begin bad++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 fff0", c, out_valid, out_imm); end
    end
    set_in(1, 0, 3'd1, 12'h001, 1, 0);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_imm !== 16'h0001) begin bad++; $display("FAIL bp_release: got v=%b %h want v=1 0001", out_valid, out_imm); end
  endtask

  task automatic test_flush();
    set_in(1, 1, 3'd1, 12'h0AB, 1, 0);
    tick();
    set_in(1, 0, 3'd1, 12'h055, 1, 1);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    set_in(1, 0, 3'd1, 12'h080, 1, 0);
    tick();
    total++; if (out_valid !== 1'b1 || out_imm !== 16'hFF80) begin bad++; $display("FAIL flush_after: got v=%b %h want v=1 ff80", out_valid, out_imm); end
  endtask

  task automatic test_async_reset();
    set_in(1, 0, 3'd1, 12'h07F, 1, 0);
    tick();
    set_in(0, 0, 3'd0, 12'h0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0 || out_imm !== 16'h0 || out_err !== 1'b0) begin bad++; $display("FAIL arst_clear: got v=%b %h e=%b want v=0 0000 e=0", out_valid, out_imm, out_err); end
    rst_n = 1'b1;
    set_in(1, 1, 3'd0, 12'h099, 1, 0);
    tick();
    set_in(0, 0, 3'd0, 12'h0, 1, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    set_in(1, 0, 3'd1, 12'h001, 1, 0);
    tick();
    total++; if (out_valid !== 1'b1 || out_imm !== 16'h0001 || out_err !== 1'b0) begin bad++; $display("FAIL arst_pfx_cleared: got v=%b %h e=%b want v=1 0001 e=0", out_valid, out_imm, out_err); end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
             12'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      #1;
      exp_rdy = !flush && (!m_ov || out_ready);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy); end
      tick();
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, m_ov); end
      if (m_ov) begin
        total++; if (out_imm !== m_imm || out_err !== m_err) begin bad++; $display("FAIL rand_data[%0d]: got %h e=%b want %h e=%b", c, out_imm, out_err, m_imm, m_err); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_prefix();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
